// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor: table of 2-bit saturating counters indexed by PC,
// with saturating branch/mispredict statistics. Define BP_GSHARE_EN to XOR a global history into the index.
module branch_predictor #(
  parameter int INDEX_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_pc,
  output logic        br_prediction,
  input  logic        update_valid,
  input  logic [15:0] update_pc,
  input  logic        update_taken,
  input  logic        update_mispredict,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  logic [1:0]            table_q [DEPTH];
  logic [1:0]            table_d [DEPTH];
  logic [15:0]           branch_count_q, branch_count_d;
  logic [15:0]           mispredict_count_q, mispredict_count_d;
  logic [INDEX_BITS-1:0] lookup_idx_s;
  logic [INDEX_BITS-1:0] update_idx_s;
  logic                  unused_pc_bits_s;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? 16'hFFFF : c + 16'h0001;
  endfunction

  // Instructions are word-aligned and the table only sees the low index bits.
  assign unused_pc_bits_s = ^{fetch_pc[15:INDEX_BITS+1], fetch_pc[0],
                              update_pc[15:INDEX_BITS+1], update_pc[0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // Both indices use the pre-shift history of the current cycle.
  assign lookup_idx_s = fetch_pc[INDEX_BITS:1] ^ ghr_q;
  assign update_idx_s = update_pc[INDEX_BITS:1] ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) begin
      ghr_d = {ghr_q[INDEX_BITS-2:0], update_taken};
    end else begin
      ghr_d = ghr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lookup_idx_s = fetch_pc[INDEX_BITS:1];
  assign update_idx_s = update_pc[INDEX_BITS:1];
`endif

  // No write-to-read bypass: a same-cycle lookup sees the pre-update counter.
  assign br_prediction = table_q[lookup_idx_s][1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      table_d[i] = table_q[i];
    end
    if (update_valid) begin
      if (update_taken) begin
        table_d[update_idx_s] = sat_inc2(table_q[update_idx_s]);
      end else begin
        table_d[update_idx_s] = sat_dec2(table_q[update_idx_s]);
      end
    end else begin
      table_d[update_idx_s] = table_q[update_idx_s];
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_valid) begin
      branch_count_d = sat_inc16(branch_count_q);
      if (update_mispredict) begin
        mispredict_count_d = sat_inc16(mispredict_count_q);
      end else begin
        mispredict_count_d = mispredict_count_q;
      end
    end else begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= 2'b01;
      end
      branch_count_q     <= 16'h0000;
      mispredict_count_q <= 16'h0000;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
